// File: rtl/dmem_responder_if.sv
// Load/store request and response bundle between the MEM stage and the data memory.
// Latency: none, this is wiring only.
// Backpressure: req_ready from the memory side gates acceptance; mem_stall freezes the pipeline.
interface dmem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [1:0]  req_size;
    logic        req_signed;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_stall;

    // Pipeline (MEM stage) side
    modport master (
        output req_valid, req_write, req_addr, req_wdata, req_size, req_signed,
        input  req_ready, resp_valid, resp_rdata, resp_err, mem_stall
    );

    // Data memory side
    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, req_size, req_signed,
        output req_ready, resp_valid, resp_rdata, resp_err, mem_stall
    );
endinterface

// File: rtl/dmem_responder.sv
// Multi-cycle data memory: word/half/byte loads and stores with sign or zero extension.
// Latency: accept at edge N gives a one-cycle resp_valid in cycle N+LATENCY; one access per LATENCY+1 cycles.
// Backpressure: req_ready low while BUSY; mem_stall holds the pipeline until the response cycle.
// Optional feature: define DMEM_MISALIGN_TRAP_EN to flag misaligned accesses on resp_err and suppress them.
module dmem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic              Clk,
    input  logic              Reset,
    dmem_responder_if.slave   bus
);
    localparam int AW = $clog2(DEPTH_WORDS);
    localparam logic [3:0] CNT_LAST = 4'(LATENCY - 1);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t        state, state_nxt;
    logic [3:0]    cnt, cnt_nxt;

    logic          wr_q;
    logic [AW+1:0] addr_q;
    logic [31:0]   wdata_q;
    logic [1:0]    size_q;
    logic          signed_q;

    logic [31:0]   mem [DEPTH_WORDS];
    logic [31:0]   mem_word;
    logic [31:0]   wr_word;
    logic [31:0]   load_val;
    logic [31:0]   rdata_q;
    logic          misalign;
    logic          accept;
    logic          commit;
    logic          unused_addr_hi;

    // Address bits above the storage size are ignored, so accesses wrap.
    assign unused_addr_hi = ^bus.req_addr[31:AW+2];

    assign bus.req_ready = (state == IDLE) || (state == RESP);
    assign accept        = bus.req_valid && bus.req_ready;
    assign commit        = (state == BUSY) && (cnt == CNT_LAST);
    assign mem_word      = mem[addr_q[AW+1:2]];

    assign bus.resp_valid = (state == RESP);
    assign bus.resp_rdata = rdata_q;
    assign bus.mem_stall  = (state == BUSY) || (state == IDLE && bus.req_valid)
                          || (state == RESP && bus.req_valid);

`ifdef DMEM_MISALIGN_TRAP_EN
    logic err_q;

    // Half needs addr[0]=0; word (and size 11) needs addr[1:0]=0.
    always_comb begin
        misalign = 1'b0;
        case (size_q)
            2'b01:   misalign = addr_q[0];
            2'b10:   misalign = 1'b0;
            default: misalign = (addr_q[1:0] != 2'b00);
        endcase
    end

    // Error flag captured at commit, presented only during the response pulse.
    always_ff @(posedge Clk) begin
        if (Reset)       err_q <= 1'b0;
        else if (commit) err_q <= misalign;
    end

    assign bus.resp_err = err_q && (state == RESP);
`else
    // Without trapping, low address bits below the access size are simply not looked at.
    assign misalign     = 1'b0;
    assign bus.resp_err = 1'b0;
`endif

    // State register; reset abandons any access in flight.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next-state: count BUSY cycles, pulse RESP, re-enter BUSY on a back-to-back accept.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = BUSY;
                    cnt_nxt   = 4'd0;
                end
            end
            BUSY: begin
                if (commit) begin
                    state_nxt = RESP;
                    cnt_nxt   = 4'd0;
                end else begin
                    cnt_nxt = cnt + 4'd1;
                end
            end
            RESP: begin
                if (accept) begin
                    state_nxt = BUSY;
                    cnt_nxt   = 4'd0;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = 4'd0;
            end
        endcase
    end

    // Hold the accepted request for the whole access; the pipeline may drop req_valid.
    always_ff @(posedge Clk) begin
        if (!Reset && accept) begin
            wr_q     <= bus.req_write;
            addr_q   <= bus.req_addr[AW+1:0];
            wdata_q  <= bus.req_wdata;
            size_q   <= bus.req_size;
            signed_q <= bus.req_signed;
        end
    end

    // Little-endian lane select, right-justify, then extend.
    always_comb begin
        load_val = mem_word;
        case (size_q)
            2'b10: begin
                load_val = {24'd0, mem_word[{addr_q[1:0], 3'b000} +: 8]};
                if (signed_q) load_val[31:8] = {24{load_val[7]}};
            end
            2'b01: begin
                load_val = {16'd0, (addr_q[1] ? mem_word[31:16] : mem_word[15:0])};
                if (signed_q) load_val[31:16] = {16{load_val[15]}};
            end
            default: load_val = mem_word;
        endcase
    end

    // Merge store data into the existing word so untouched lanes are preserved.
    always_comb begin
        wr_word = mem_word;
        case (size_q)
            2'b10:   wr_word[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
            2'b01: begin
                if (addr_q[1]) wr_word[31:16] = wdata_q[15:0];
                else           wr_word[15:0]  = wdata_q[15:0];
            end
            default: wr_word = wdata_q;
        endcase
    end

    // Storage is never cleared; a store is dropped if reset coincides with its commit edge.
    always_ff @(posedge Clk) begin
        if (!Reset && commit && wr_q && !misalign)
            mem[addr_q[AW+1:2]] <= wr_word;
    end

    // Read data captured at commit and held until the next response; stores and traps return 0.
    always_ff @(posedge Clk) begin
        if (Reset)       rdata_q <= 32'd0;
        else if (commit) rdata_q <= (wr_q || misalign) ? 32'd0 : load_val;
    end
endmodule
